clk_enable_divider: RTL and testbench

Multi-channel programmable clock-enable generator that produces, per channel, a one-cycle tick every D cycles of `inClk` and a registered square wave of period 2·D. All channels run in the single `inClk` domain, so downstream logic uses `tickOut` as a clock enable instead of a derived clock. The block generalises the power-of-two ripple divider to arbitrary integer ratios, several independent channels, per-channel enables, glitch-free ratio updates and a common phase-sync input.

---
 rtl/clk_enable_divider_if.sv | 11 +
 rtl/clk_enable_divider.sv | 110 +++++++++++
 tb/tb_clk_enable_divider.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/clk_enable_divider_if.sv
// rtl/clk_enable_divider_if.sv - divisor write port shared by all divider channels
interface clk_enable_divider_if #(
    parameter int CNT_W = 16
) ();
    logic             wrEn;
    logic [3:0]       wrCh;
    logic [CNT_W-1:0] wrData;

    modport master (output wrEn, output wrCh, output wrData);
    modport slave  (input  wrEn, input  wrCh, input  wrData);
endinterface

// File: rtl/clk_enable_divider.sv
// rtl/clk_enable_divider.sv - multi-channel programmable clock-enable generator
module clk_enable_divider #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int RESET_DIV = 2
) (
    input  logic                inClk,
    input  logic                resetN,
    input  logic [NUM_CH-1:0]   chEn,
    input  logic                syncIn,
    clk_enable_divider_if.slave wr,
    output logic [NUM_CH-1:0]   tickOut,
    output logic [NUM_CH-1:0]   outClk,
    output logic [NUM_CH-1:0]   updPending
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(RESET_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  act_q  [NUM_CH];
    logic [CNT_W-1:0]  act_d  [NUM_CH];
    logic [CNT_W-1:0]  pend_q [NUM_CH];
    logic [CNT_W-1:0]  pend_d [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] oclk_q, oclk_d;
    logic [NUM_CH-1:0] upd_q, upd_d;
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] wrap;
    logic [CNT_W-1:0]  wr_data;

    assign wr_data = wr.wrData;

    // Per-channel write decode and wrap detection; a divisor of 0 behaves as 1.
    // Writes to channel numbers >= NUM_CH match no channel and are dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] deff;
        assign wr_hit[i] = wr.wrEn && (wr.wrCh == 4'(i));
        assign deff      = (act_q[i] == '0) ? ONE : act_q[i];
        assign wrap[i]   = (cnt_q[i] == deff - ONE);
    end

    // Next-state per channel: disabled > sync/restart > wrap > count.
    // Sync and wrap load the pending ratio as it stood before any write
    // landing in the same cycle, so such a write waits for the next wrap.
    always_comb begin
        tick_d = '0;
        oclk_d = oclk_q;
        upd_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            act_d[i]  = act_q[i];
            pend_d[i] = pend_q[i];
            if (wr_hit[i]) begin
                pend_d[i] = wr_data;
            end
            if (!chEn[i]) begin
                cnt_d[i]  = '0;
                oclk_d[i] = 1'b0;
                act_d[i]  = wr_hit[i] ? wr_data : pend_q[i];
            end else if (syncIn || !en_q[i]) begin
                // A freshly enabled channel restarts its phase like a sync,
                // so its first tick lands Deff cycles after the enable.
                cnt_d[i]  = '0;
                oclk_d[i] = 1'b0;
                act_d[i]  = pend_q[i];
            end else if (wrap[i]) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                oclk_d[i] = ~oclk_q[i];
                act_d[i]  = pend_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
            end
            upd_d[i] = (pend_q[i] != act_q[i]);
        end
    end

    // Channel state registers with asynchronous clear.
    always_ff @(posedge inClk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                act_q[i]  <= RST_DIV;
                pend_q[i] <= RST_DIV;
            end
            tick_q <= '0;
            oclk_q <= '0;
            upd_q  <= '0;
            en_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                act_q[i]  <= act_d[i];
                pend_q[i] <= pend_d[i];
            end
            tick_q <= tick_d;
            oclk_q <= oclk_d;
            upd_q  <= upd_d;
            en_q   <= chEn;
        end
    end

    assign tickOut    = tick_q;
    assign outClk     = oclk_q;
    assign updPending = upd_q;

endmodule

// File: tb/tb_clk_enable_divider.sv
// tb/tb_clk_enable_divider.sv - directed self-checking bench for clk_enable_divider
module tb_clk_enable_divider;

    logic       inClk;
    logic       resetN;
    logic [3:0] chEn;
    logic       syncIn;
    logic [3:0] tickOut;
    logic [3:0] outClk;
    logic [3:0] updPending;

    int tests;
    int failed;

    clk_enable_divider_if #(.CNT_W(16)) wr_bus ();

    clk_enable_divider #(
        .NUM_CH    (4),
        .CNT_W     (16),
        .RESET_DIV (2)
    ) dut (
        .inClk      (inClk),
        .resetN     (resetN),
        .chEn       (chEn),
        .syncIn     (syncIn),
        .wr         (wr_bus),
        .tickOut    (tickOut),
        .outClk     (outClk),
        .updPending (updPending)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] ch, input logic [15:0] d);
        wr_bus.wrEn   = 1'b1;
        wr_bus.wrCh   = ch;
        wr_bus.wrData = d;
    endtask

    initial begin
        logic [63:0] tv0, ov0, tv1, ov1, uv;
        logic [3:0]  other;
        int          first;

        tests = 0;
        failed = 0;
        resetN = 1'b0;
        chEn = 4'b0000;
        syncIn = 1'b0;
        wr_bus.wrEn = 1'b0;
        wr_bus.wrCh = 4'd0;
        wr_bus.wrData = 16'd0;

        // Reset state
        repeat (2) @(negedge inClk);
        check("rst_tick", 64'(tickOut), 64'h0);
        check("rst_outclk", 64'(outClk), 64'h0);
        check("rst_upd", 64'(updPending), 64'h0);

        // Reset defaults: ch0 alone at D=2
        resetN = 1'b1;
        chEn = 4'b0001;
        tv0 = '0; ov0 = '0; other = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge inClk);
            tv0[k] = tickOut[0];
            ov0[k] = outClk[0];
            other = other | tickOut[3:1] | outClk[3:1] | updPending;
        end
        check("def_tick", tv0, 64'h54);
        check("def_outclk", ov0, 64'hCC);
        check("def_others_quiet", 64'(other), 64'h0);

        // Glitch-free ratio change: D=5 running, write D=3 with cnt=2
        chEn = 4'b0000;
        do_write(4'd0, 16'd5);
        @(negedge inClk);
        wr_bus.wrEn = 1'b0;
        chEn = 4'b0001;
        tv0 = '0; uv = '0;
        for (int k = 0; k < 15; k++) begin
            @(negedge inClk);
            tv0[k] = tickOut[0];
            uv[k] = updPending[0];
            if (k == 2) do_write(4'd0, 16'd3);
            if (k == 3) wr_bus.wrEn = 1'b0;
        end
        check("chg_tick", tv0, 64'h4920);
        check("chg_upd", uv, 64'h30);

        // Sync alignment: ch0 and ch1 at D=4 started two cycles apart
        chEn = 4'b0000;
        do_write(4'd0, 16'd4);
        @(negedge inClk);
        do_write(4'd1, 16'd4);
        @(negedge inClk);
        wr_bus.wrEn = 1'b0;
        chEn = 4'b0001;
        repeat (2) @(negedge inClk);
        chEn = 4'b0011;
        other = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge inClk);
            if (tickOut[1:0] == 2'b11) other[0] = 1'b1;
        end
        check("presync_misaligned", 64'(other), 64'h0);
        syncIn = 1'b1;
        tv0 = '0; ov0 = '0; tv1 = '0; ov1 = '0;
        for (int k = 0; k < 13; k++) begin
            @(negedge inClk);
            if (k == 0) syncIn = 1'b0;
            tv0[k] = tickOut[0];
            ov0[k] = outClk[0];
            tv1[k] = tickOut[1];
            ov1[k] = outClk[1];
        end
        check("sync_tick0", tv0, 64'h1110);
        check("sync_tick1", tv1, 64'h1110);
        check("sync_outclk0", ov0, 64'h10F0);
        check("sync_outclk1", ov1, 64'h10F0);

        // Edge divisors: ch2 D=0, ch3 D=1
        chEn = 4'b0000;
        do_write(4'd2, 16'd0);
        @(negedge inClk);
        do_write(4'd3, 16'd1);
        @(negedge inClk);
        wr_bus.wrEn = 1'b0;
        chEn = 4'b1100;
        tv0 = '0; ov0 = '0; tv1 = '0; ov1 = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge inClk);
            tv0[k] = tickOut[2];
            ov0[k] = outClk[2];
            tv1[k] = tickOut[3];
            ov1[k] = outClk[3];
        end
        check("d0_tick", tv0, 64'hFE);
        check("d0_outclk", ov0, 64'hAA);
        check("d1_tick", tv1, 64'hFE);
        check("d1_outclk", ov1, 64'hAA);

        // Disabled write to ch2 and a write to nonexistent channel 9
        chEn = 4'b0000;
        do_write(4'd2, 16'd7);
        @(negedge inClk);
        do_write(4'd9, 16'd3);
        @(negedge inClk);
        wr_bus.wrEn = 1'b0;
        chEn = 4'b0110;
        tv0 = '0; tv1 = '0; other = '0;
        for (int k = 0; k < 9; k++) begin
            @(negedge inClk);
            tv0[k] = tickOut[2];
            tv1[k] = tickOut[1];
            other = other | updPending;
        end
        check("dis_wr_tick2", tv0, 64'h080);
        check("bad_ch_tick1", tv1, 64'h110);
        check("dis_wr_upd", 64'(other), 64'h0);

        // Maximum divisor: first tick 65535 cycles after enable
        chEn = 4'b0000;
        do_write(4'd0, 16'hFFFF);
        @(negedge inClk);
        wr_bus.wrEn = 1'b0;
        chEn = 4'b0001;
        first = -1;
        for (int k = 0; k < 70000; k++) begin
            @(negedge inClk);
            if (tickOut[0]) begin
                first = k;
                break;
            end
        end
        check("max_div_spacing", 64'(first), 64'd65535);
        check("max_div_outclk", 64'(outClk[0]), 64'h1);

        // Async reset mid-operation
        chEn = 4'b1001;
        do_write(4'd0, 16'd5);
        @(negedge inClk);
        wr_bus.wrEn = 1'b0;
        repeat (2) @(negedge inClk);
        check("pre_rst_tick3", 64'(tickOut[3]), 64'h1);
        check("pre_rst_upd0", 64'(updPending[0]), 64'h1);
        #2;
        resetN = 1'b0;
        #1;
        check("arst_tick", 64'(tickOut), 64'h0);
        check("arst_outclk", 64'(outClk), 64'h0);
        check("arst_upd", 64'(updPending), 64'h0);
        @(negedge inClk);
        resetN = 1'b1;
        tv0 = '0; ov0 = '0; tv1 = '0; other = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge inClk);
            tv0[k] = tickOut[0];
            ov0[k] = outClk[0];
            tv1[k] = tickOut[3];
            other = other | updPending;
        end
        check("post_rst_tick0", tv0, 64'h54);
        check("post_rst_outclk0", ov0, 64'hCC);
        check("post_rst_tick3", tv1, 64'h54);
        check("post_rst_upd", 64'(other), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
